// File: rtl/mem_arbiter_if.sv
// Bundles the requester side and the memory side of mem_arbiter.
// The slave modport is the arbiter's view. The master modport is the view of
// whatever drives the requests and models the memory.
interface mem_arbiter_if #(
  parameter int AW = 16,
  parameter int DW = 16
);
  // Requester side
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          d_rd;
  logic          d_wr;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [DW-1:0] rdata;
  logic          if_done;
  logic          d_done;
  logic          if_stall;
  logic          d_stall;
  logic          busy;
  // Memory side
  logic [DW-1:0] mem_rdata;
  logic          mem_en;
  logic          mem_wr;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;

  // Handshake: a requester raises if_req or d_rd/d_wr and holds it until the
  // matching one-cycle done pulse. Requests are only looked at while the
  // arbiter is idle. mem_en is a single-cycle strobe per access.
  modport slave (
    input  if_req, if_addr, d_rd, d_wr, d_addr, d_wdata, mem_rdata,
    output mem_en, mem_wr, mem_addr, mem_wdata, rdata,
           if_done, d_done, if_stall, d_stall, busy
  );

  modport master (
    output if_req, if_addr, d_rd, d_wr, d_addr, d_wdata, mem_rdata,
    input  mem_en, mem_wr, mem_addr, mem_wdata, rdata,
           if_done, d_done, if_stall, d_stall, busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-ported, fixed-latency memory between
// instruction fetch and data access. Data normally wins over fetch.
// Optional macro ARB_FAIR_EN: after MAX_STREAK consecutive data grants made
// while fetch waits, the next grant goes to fetch.
module mem_arbiter #(
  parameter int AW         = 16,
  parameter int DW         = 16,
  parameter int MEM_LAT    = 4,
  parameter int MAX_STREAK = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  mem_arbiter_if.slave       bus,
  output logic [1:0]         state_o   // debug view of the FSM state
);

  localparam int CW = $clog2(MEM_LAT + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic          own_data_q;
  logic          mem_en_q;
  logic          mem_wr_q;
  logic [AW-1:0] mem_addr_q;
  logic [DW-1:0] mem_wdata_q;
  logic [DW-1:0] rdata_q;
  logic          if_done_q;
  logic          d_done_q;

  logic data_req;
  logic grant_data_d;

`ifdef ARB_FAIR_EN
  localparam int SW = $clog2(MAX_STREAK + 1);
  logic [SW-1:0] streak_q;
`endif

  assign data_req = bus.d_rd | bus.d_wr;

  // Grant decision for the current IDLE cycle: data first, unless fetch has
  // been passed over MAX_STREAK times in a row.
  always_comb begin
`ifdef ARB_FAIR_EN
    grant_data_d = data_req & ~(bus.if_req & (streak_q == SW'(MAX_STREAK)));
`else
    grant_data_d = data_req;
`endif
  end

  // Main FSM: arbitrate in IDLE, count out the memory latency in ACCESS,
  // pulse the owner's done in RESP. All outputs are registered here.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      own_data_q  <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
      if_done_q   <= 1'b0;
      d_done_q    <= 1'b0;
`ifdef ARB_FAIR_EN
      streak_q    <= '0;
`endif
    end else begin
      mem_en_q  <= 1'b0;
      if_done_q <= 1'b0;
      d_done_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (data_req || bus.if_req) begin
            own_data_q  <= grant_data_d;
            // Both d_rd and d_wr high counts as a write.
            mem_wr_q    <= grant_data_d & bus.d_wr;
            mem_addr_q  <= grant_data_d ? bus.d_addr : bus.if_addr;
            mem_wdata_q <= bus.d_wdata;
            mem_en_q    <= 1'b1;
            cnt_q       <= CW'(MEM_LAT - 1);
            state_q     <= ACCESS;
`ifdef ARB_FAIR_EN
            // Only data grants that made fetch wait extend the streak.
            if (grant_data_d && bus.if_req) streak_q <= streak_q + 1'b1;
            else                            streak_q <= '0;
`endif
          end
        end
        ACCESS: begin
          if (cnt_q == '0) begin
            if (!mem_wr_q) rdata_q <= bus.mem_rdata;
            if_done_q <= ~own_data_q;
            d_done_q  <= own_data_q;
            state_q   <= RESP;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        RESP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.mem_en    = mem_en_q;
  assign bus.mem_wr    = mem_wr_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.rdata     = rdata_q;
  assign bus.if_done   = if_done_q;
  assign bus.d_done    = d_done_q;
  assign bus.if_stall  = bus.if_req & ~if_done_q;
  assign bus.d_stall   = data_req & ~d_done_q;
  assign bus.busy      = (state_q != IDLE);
  assign state_o       = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: directed scenarios followed by randomized
// request mixes, each checked cycle by cycle against a transaction-level model
// (who wins, when done fires, what the memory sees, what rdata holds).
module tb_mem_arbiter;
  localparam int AW         = 16;
  localparam int DW         = 16;
  localparam int MEM_LAT    = 4;
  localparam int MAX_STREAK = 3;
`ifdef ARB_FAIR_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic       clk;
  logic       rst_n;
  logic [1:0] dbg_state;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  mem_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(MEM_LAT), .MAX_STREAK(MAX_STREAK)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .state_o (dbg_state)
  );

  // ---------------- model state ----------------
  int            checks;
  int            failures;
  bit            ipend;
  logic [AW-1:0] iaddr_m;
  bit            dpend_rd;
  bit            dpend_wr;
  logic [AW-1:0] daddr_m;
  logic [DW-1:0] dwdata_m;
  logic [DW-1:0] rdata_m;
  logic [DW-1:0] mem_rdata_v;
  int            streak_m;

  // ---------------- driver / checker tasks ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    bus.if_req    = ipend;
    bus.if_addr   = iaddr_m;
    bus.d_rd      = dpend_rd;
    bus.d_wr      = dpend_wr;
    bus.d_addr    = daddr_m;
    bus.d_wdata   = dwdata_m;
    bus.mem_rdata = mem_rdata_v;
  endtask

  // Called at a falling edge while the arbiter is idle with at least one
  // request pending. Runs one full access and checks every cycle of it.
  task automatic serve(input bit drop_mid, input logic [DW-1:0] rv);
    bit            own_d;
    bit            wr;
    bit            fin;
    logic [AW-1:0] a;
    logic [DW-1:0] wd;
    own_d = (dpend_rd || dpend_wr) && (!ipend || !FAIR || streak_m < MAX_STREAK);
    if (own_d) streak_m = ipend ? streak_m + 1 : 0;
    else       streak_m = 0;
    wr = own_d && dpend_wr;
    a  = own_d ? daddr_m : iaddr_m;
    wd = dwdata_m;
    for (int c = 0; c <= MEM_LAT + 1; c++) begin
      // Memory only presents valid data MEM_LAT cycles after the strobe.
      mem_rdata_v = (c == MEM_LAT) ? rv : DW'($urandom);
      if (drop_mid && c == 2) begin
        if (own_d) begin dpend_rd = 1'b0; dpend_wr = 1'b0; end
        else ipend = 1'b0;
      end
      drive();
      #1;
      fin = (c == MEM_LAT + 1);
      if (fin && !wr) rdata_m = rv;
      chk("busy",     32'(bus.busy),     32'(c != 0));
      chk("mem_en",   32'(bus.mem_en),   32'(c == 1));
      if (c >= 1) begin
        chk("mem_addr", 32'(bus.mem_addr), 32'(a));
        chk("mem_wr",   32'(bus.mem_wr),   32'(wr));
        if (wr) chk("mem_wdata", 32'(bus.mem_wdata), 32'(wd));
      end
      chk("if_done",  32'(bus.if_done),  32'(fin && !own_d));
      chk("d_done",   32'(bus.d_done),   32'(fin && own_d));
      chk("if_stall", 32'(bus.if_stall), 32'(ipend && !(fin && !own_d)));
      chk("d_stall",  32'(bus.d_stall),  32'((dpend_rd || dpend_wr) && !(fin && own_d)));
      chk("rdata",    32'(bus.rdata),    32'(rdata_m));
      @(negedge clk);
    end
    // The owner drops its request once done has been seen.
    if (own_d) begin dpend_rd = 1'b0; dpend_wr = 1'b0; end
    else ipend = 1'b0;
    drive();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    checks = 0; failures = 0;
    ipend = 0; iaddr_m = '0; dpend_rd = 0; dpend_wr = 0;
    daddr_m = '0; dwdata_m = '0; rdata_m = '0; mem_rdata_v = '0; streak_m = 0;
    rst_n = 1'b0;
    drive();
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_busy",   32'(bus.busy),      32'd0);
    chk("rst_mem_en", 32'(bus.mem_en),    32'd0);
    chk("rst_mem_wr", 32'(bus.mem_wr),    32'd0);
    chk("rst_addr",   32'(bus.mem_addr),  32'd0);
    chk("rst_wdata",  32'(bus.mem_wdata), 32'd0);
    chk("rst_rdata",  32'(bus.rdata),     32'd0);
    chk("rst_ifdone", 32'(bus.if_done),   32'd0);
    chk("rst_ddone",  32'(bus.d_done),    32'd0);
    chk("rst_state",  32'(dbg_state),     32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Fetch alone
    ipend = 1; iaddr_m = 16'h0040;
    serve(1'b0, 16'hBEEF);

    // Data write; rdata must keep 0xBEEF
    dpend_wr = 1; daddr_m = 16'h1000; dwdata_m = 16'h1234;
    serve(1'b0, 16'h5A5A);

    // Fetch and data read together: data first, then fetch
    ipend = 1; iaddr_m = 16'h0080; dpend_rd = 1; daddr_m = 16'h2000;
    serve(1'b0, 16'hC0DE);
    serve(1'b0, 16'h0F0F);

    // Read and write both high counts as a write
    dpend_rd = 1; dpend_wr = 1; daddr_m = 16'h0008; dwdata_m = 16'hAAAA;
    serve(1'b0, 16'h7777);

    // Request dropped mid-access still completes
    dpend_rd = 1; daddr_m = 16'h3000;
    serve(1'b1, 16'h2468);

    // Data held continuously with fetch waiting
    ipend = 1; iaddr_m = 16'h0100; daddr_m = 16'h4000;
    for (int k = 0; k < 7; k++) begin
      dpend_rd = 1;
      serve(1'b0, DW'($urandom));
    end
    dpend_rd = 0;
    if (ipend) serve(1'b0, DW'($urandom));

    // Reset in the middle of an access
    dpend_rd = 1; daddr_m = 16'h5000; mem_rdata_v = 16'h9999;
    drive();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0; dpend_rd = 0;
    drive();
    @(negedge clk);
    rst_n = 1'b1; rdata_m = '0; streak_m = 0;
    #1;
    chk("midrst_busy",   32'(bus.busy),    32'd0);
    chk("midrst_mem_en", 32'(bus.mem_en),  32'd0);
    chk("midrst_ddone",  32'(bus.d_done),  32'd0);
    chk("midrst_rdata",  32'(bus.rdata),   32'd0);
    @(negedge clk);
    #1;
    chk("midrst_ddone2", 32'(bus.d_done),  32'd0);
    chk("midrst_busy2",  32'(bus.busy),    32'd0);
    @(negedge clk);
    dpend_rd = 1; daddr_m = 16'h5004;
    serve(1'b0, 16'h1357);

    // Randomized request mixes
    for (int n = 0; n < 40; n++) begin
      if (!ipend && $urandom_range(0, 1) == 1) begin
        ipend = 1; iaddr_m = AW'($urandom);
      end
      if (!dpend_rd && !dpend_wr && $urandom_range(0, 2) != 0) begin
        case ($urandom_range(0, 2))
          0: begin dpend_rd = 1; dpend_wr = 0; end
          1: begin dpend_rd = 0; dpend_wr = 1; end
          default: begin dpend_rd = 1; dpend_wr = 1; end
        endcase
        daddr_m = AW'($urandom); dwdata_m = DW'($urandom);
      end
      if (!ipend && !dpend_rd && !dpend_wr) begin
        ipend = 1; iaddr_m = AW'($urandom);
      end
      serve($urandom_range(0, 7) == 0, DW'($urandom));
    end
    while (ipend || dpend_rd || dpend_wr) serve(1'b0, DW'($urandom));

    // Quiet cycle: nothing should start
    @(negedge clk);
    #1;
    chk("idle_busy",   32'(bus.busy),   32'd0);
    chk("idle_mem_en", 32'(bus.mem_en), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
